// File: rtl/data_cache_controller_if.sv
// Pipeline M-stage access signals and word-wide backing-memory bus of the L1 data cache.
// The slave modport is the cache controller; master is the pipeline/memory side.
interface data_cache_controller_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  memory_instruction_i;
    logic                  write_enable_i;
    logic                  byte_op_i;
    logic [DATA_WIDTH-1:0] address_i;
    logic [DATA_WIDTH-1:0] write_data_i;
    logic [DATA_WIDTH-1:0] rd_o;
    logic                  stall_o;
    logic                  mem_req_o;
    logic                  mem_we_o;
    logic [DATA_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic [3:0]            mem_wstrb_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;
    logic                  mem_ack_i;

    modport slave (
        input  memory_instruction_i, write_enable_i, byte_op_i, address_i, write_data_i,
        input  mem_rdata_i, mem_ack_i,
        output rd_o, stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o
    );

    modport master (
        output memory_instruction_i, write_enable_i, byte_op_i, address_i, write_data_i,
        output mem_rdata_i, mem_ack_i,
        input  rd_o, stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o
    );
endinterface

// File: rtl/data_cache_controller.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache with one-word lines.
// Define CACHE_STATS_EN to add saturating hit/miss counters (hit_count_o, miss_count_o).
module data_cache_controller #(
    parameter int DATA_WIDTH = 32,
    parameter int INDEX_BITS = 4
) (
    input  logic                   clk,
    input  logic                   rst_i,
    data_cache_controller_if.slave bus
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]            hit_count_o,
    output logic [31:0]            miss_count_o
`endif
);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = DATA_WIDTH - INDEX_BITS - 2;

    typedef enum logic [1:0] {IDLE, READ_MISS, WRITE, RESP} state_e;

    state_e                  state_q, state_d;
    logic [LINES-1:0]        valid_q;
    logic [TAG_BITS-1:0]     tag_q  [LINES];
    logic [DATA_WIDTH-1:0]   data_q [LINES];
    logic [DATA_WIDTH-3:0]   req_word_q;
    logic [DATA_WIDTH-1:0]   req_wdata_q;
    logic [3:0]              req_wstrb_q;

    logic [1:0]              offset;
    logic [INDEX_BITS-1:0]   index;
    logic [TAG_BITS-1:0]     tag;
    logic [4:0]              lane;
    logic [DATA_WIDTH-1:0]   line_word;
    logic                    hit, load_hit;
    logic [DATA_WIDTH-1:0]   store_wdata, merged_word;
    logic [3:0]              store_strb;
    logic                    stall, mem_req, mem_we, refill, store_update;
    logic [3:0]              mem_wstrb;

    assign offset    = bus.address_i[1:0];
    assign index     = bus.address_i[INDEX_BITS+1:2];
    assign tag       = bus.address_i[DATA_WIDTH-1:INDEX_BITS+2];
    assign lane      = {offset, 3'b000};
    assign line_word = data_q[index];
    assign hit       = bus.memory_instruction_i & valid_q[index] & (tag_q[index] == tag);
    assign load_hit  = hit & ~bus.write_enable_i;

    assign store_wdata = bus.byte_op_i ? {(DATA_WIDTH/8){bus.write_data_i[7:0]}} : bus.write_data_i;
    assign store_strb  = bus.byte_op_i ? (4'b0001 << offset) : 4'b1111;

    // Store hits write only the strobed lanes so byte stores keep the rest of the line.
    always_comb begin
        merged_word = line_word;
        for (int i = 0; i < DATA_WIDTH/8; i++) begin
            if (store_strb[i]) merged_word[i*8 +: 8] = store_wdata[i*8 +: 8];
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            req_word_q  <= '0;
            req_wdata_q <= '0;
            req_wstrb_q <= '0;
        end else begin
            state_q <= state_d;
            // Latch the request so the memory bus stays stable until ack.
            if (state_q == IDLE && bus.memory_instruction_i) begin
                req_word_q  <= bus.address_i[DATA_WIDTH-1:2];
                req_wdata_q <= store_wdata;
                req_wstrb_q <= store_strb;
            end
        end
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no path infers a latch.
        state_d      = state_q;
        stall        = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_wstrb    = 4'b0000;
        refill       = 1'b0;
        store_update = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.memory_instruction_i) begin
                    if (bus.write_enable_i) begin
                        stall        = 1'b1;
                        store_update = hit;
                        state_d      = WRITE;
                    end else if (!hit) begin
                        stall   = 1'b1;
                        state_d = READ_MISS;
                    end
                end
            end
            READ_MISS: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                if (bus.mem_ack_i) begin
                    refill  = 1'b1;
                    state_d = RESP;
                end
            end
            WRITE: begin
                stall     = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_wstrb = req_wstrb_q;
                if (bus.mem_ack_i) state_d = RESP;
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) valid_q <= '0;
        else if (refill) valid_q[req_word_q[INDEX_BITS-1:0]] <= 1'b1;
    end

    // NOTE: tag/data arrays are not reset; the cleared valid bits make their contents unobservable.
    always_ff @(posedge clk) begin
        if (refill) begin
            data_q[req_word_q[INDEX_BITS-1:0]] <= bus.mem_rdata_i;
            tag_q[req_word_q[INDEX_BITS-1:0]]  <= req_word_q[DATA_WIDTH-3:INDEX_BITS];
        end else if (store_update) begin
            data_q[index] <= merged_word;
        end
    end

    assign bus.rd_o        = !load_hit ? '0 :
                             bus.byte_op_i ? {{(DATA_WIDTH-8){1'b0}}, line_word[lane +: 8]} : line_word;
    assign bus.stall_o     = stall & ~rst_i;
    assign bus.mem_req_o   = mem_req;
    assign bus.mem_we_o    = mem_we;
    assign bus.mem_wstrb_o = mem_wstrb;
    assign bus.mem_addr_o  = {req_word_q, 2'b00};
    assign bus.mem_wdata_o = req_wdata_q;

`ifdef CACHE_STATS_EN
    logic [31:0] hit_count_q, miss_count_q;

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else if (state_q == IDLE) begin
            if (load_hit && hit_count_q != '1) hit_count_q <= hit_count_q + 32'd1;
            if (bus.memory_instruction_i && !bus.write_enable_i && !hit && miss_count_q != '1)
                miss_count_q <= miss_count_q + 32'd1;
        end
    end

    assign hit_count_o  = hit_count_q;
    assign miss_count_o = miss_count_q;
`endif
endmodule

// File: tb/tb_data_cache_controller.sv
// Directed bench for data_cache_controller: refill, hit, byte store merge, eviction,
// no-write-allocate store miss and asynchronous reset during an outstanding read miss.
module tb_data_cache_controller;
    logic clk = 1'b0;
    logic rst_i = 1'b1;
    int   checks = 0;
    int   passed = 0;

    data_cache_controller_if #(.DATA_WIDTH(32)) bus ();

`ifdef CACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    data_cache_controller dut (
        .clk   (clk),
        .rst_i (rst_i),
        .bus   (bus)
`ifdef CACHE_STATS_EN
        ,
        .hit_count_o  (hit_count),
        .miss_count_o (miss_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic access(input logic mi, input logic we, input logic byte_op,
                          input logic [31:0] addr, input logic [31:0] wdata);
        bus.memory_instruction_i = mi;
        bus.write_enable_i       = we;
        bus.byte_op_i            = byte_op;
        bus.address_i            = addr;
        bus.write_data_i         = wdata;
    endtask

    task automatic mem(input logic ack, input logic [31:0] rdata);
        bus.mem_ack_i   = ack;
        bus.mem_rdata_i = rdata;
    endtask

    // Advance to the next cycle's drive point (falling edge).
    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        access(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        mem(1'b0, 32'h0);
        #1;
        check("reset_stall", 32'(bus.stall_o), 32'd0);
        check("reset_req", 32'(bus.mem_req_o), 32'd0);
        check("reset_we", 32'(bus.mem_we_o), 32'd0);
        check("reset_wstrb", 32'(bus.mem_wstrb_o), 32'd0);
        check("reset_rd", bus.rd_o, 32'd0);
        next_cycle();
        rst_i = 1'b0;

        // 1: lw 0x100 misses, ack on the 3rd request cycle
        next_cycle();
        access(1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
        #1;
        check("t1_detect_stall", 32'(bus.stall_o), 32'd1);
        check("t1_detect_req", 32'(bus.mem_req_o), 32'd0);
        next_cycle(); #1;
        check("t1_req1_stall", 32'(bus.stall_o), 32'd1);
        check("t1_req1_req", 32'(bus.mem_req_o), 32'd1);
        check("t1_req1_we", 32'(bus.mem_we_o), 32'd0);
        check("t1_req1_addr", bus.mem_addr_o, 32'h100);
        next_cycle(); #1;
        check("t1_req2_stall", 32'(bus.stall_o), 32'd1);
        check("t1_req2_req", 32'(bus.mem_req_o), 32'd1);
        next_cycle();
        mem(1'b1, 32'hDEADBEEF);
        #1;
        check("t1_req3_stall", 32'(bus.stall_o), 32'd1);
        check("t1_req3_addr", bus.mem_addr_o, 32'h100);
        next_cycle();
        mem(1'b0, 32'h0);
        #1;
        check("t1_resp_stall", 32'(bus.stall_o), 32'd0);
        check("t1_resp_rd", bus.rd_o, 32'hDEADBEEF);
        check("t1_resp_req", 32'(bus.mem_req_o), 32'd0);
`ifdef CACHE_STATS_EN
        check("t1_miss_count", miss_count, 32'd1);
`endif

        // 2: lw 0x100 hits in the same cycle
        next_cycle(); #1;
        check("t2_hit_stall", 32'(bus.stall_o), 32'd0);
        check("t2_hit_req", 32'(bus.mem_req_o), 32'd0);
        check("t2_hit_rd", bus.rd_o, 32'hDEADBEEF);

        // 3: sb 0xAB to 0x101 hits, write-through with lane strobe
        next_cycle();
        access(1'b1, 1'b1, 1'b1, 32'h101, 32'h000000AB);
        #1;
        check("t3_detect_stall", 32'(bus.stall_o), 32'd1);
        check("t3_store_rd", bus.rd_o, 32'd0);
`ifdef CACHE_STATS_EN
        check("t2_hit_count", hit_count, 32'd1);
`endif
        next_cycle();
        mem(1'b1, 32'h0);
        #1;
        check("t3_req", 32'(bus.mem_req_o), 32'd1);
        check("t3_we", 32'(bus.mem_we_o), 32'd1);
        check("t3_wstrb", 32'(bus.mem_wstrb_o), 32'h2);
        check("t3_wdata", bus.mem_wdata_o, 32'hABABABAB);
        check("t3_addr", bus.mem_addr_o, 32'h100);
        next_cycle();
        mem(1'b0, 32'h0);
        #1;
        check("t3_resp_stall", 32'(bus.stall_o), 32'd0);
        check("t3_resp_req", 32'(bus.mem_req_o), 32'd0);
        check("t3_resp_wstrb", 32'(bus.mem_wstrb_o), 32'd0);
        next_cycle();
        access(1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
        #1;
        check("t3_lw_stall", 32'(bus.stall_o), 32'd0);
        check("t3_lw_rd", bus.rd_o, 32'hDEADABEF);
        next_cycle();
        access(1'b1, 1'b0, 1'b1, 32'h101, 32'h0);
        #1;
        check("t3_lbu_stall", 32'(bus.stall_o), 32'd0);
        check("t3_lbu_rd", bus.rd_o, 32'h000000AB);

        // 4: lw 0x140 evicts the 0x100 line, ack in the first request cycle
        next_cycle();
        access(1'b1, 1'b0, 1'b0, 32'h140, 32'h0);
        #1;
        check("t4_detect_stall", 32'(bus.stall_o), 32'd1);
        check("t4_detect_rd", bus.rd_o, 32'd0);
        next_cycle();
        mem(1'b1, 32'h12345678);
        #1;
        check("t4_req", 32'(bus.mem_req_o), 32'd1);
        check("t4_addr", bus.mem_addr_o, 32'h140);
        next_cycle();
        mem(1'b0, 32'h0);
        #1;
        check("t4_resp_stall", 32'(bus.stall_o), 32'd0);
        check("t4_resp_rd", bus.rd_o, 32'h12345678);
        next_cycle();
        access(1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
        #1;
        check("t4_evicted_stall", 32'(bus.stall_o), 32'd1);
        check("t4_evicted_rd", bus.rd_o, 32'd0);
        next_cycle();
        mem(1'b1, 32'h0BADF00D);
        #1;
        check("t4_refill_addr", bus.mem_addr_o, 32'h100);
        next_cycle();
        mem(1'b0, 32'h0);
        #1;
        check("t4_refill_rd", bus.rd_o, 32'h0BADF00D);

        // 5: sw to 0x200 misses, write-through without allocation
        next_cycle();
        access(1'b1, 1'b1, 1'b0, 32'h200, 32'hCAFEF00D);
        #1;
        check("t5_detect_stall", 32'(bus.stall_o), 32'd1);
        next_cycle(); #1;
        check("t5_req", 32'(bus.mem_req_o), 32'd1);
        check("t5_we", 32'(bus.mem_we_o), 32'd1);
        check("t5_wstrb", 32'(bus.mem_wstrb_o), 32'hF);
        check("t5_wdata", bus.mem_wdata_o, 32'hCAFEF00D);
        next_cycle();
        mem(1'b1, 32'h0);
        #1;
        check("t5_hold_addr", bus.mem_addr_o, 32'h200);
        check("t5_hold_wstrb", 32'(bus.mem_wstrb_o), 32'hF);
        next_cycle();
        mem(1'b0, 32'h0);
        #1;
        check("t5_resp_stall", 32'(bus.stall_o), 32'd0);
        next_cycle();
        access(1'b1, 1'b0, 1'b0, 32'h200, 32'h0);
        #1;
        check("t5_noalloc_stall", 32'(bus.stall_o), 32'd1);
        next_cycle(); #1;
        check("t5_noalloc_req", 32'(bus.mem_req_o), 32'd1);
        check("t5_noalloc_we", 32'(bus.mem_we_o), 32'd0);
        check("t5_noalloc_addr", bus.mem_addr_o, 32'h200);
        mem(1'b1, 32'h55AA55AA);
        next_cycle();
        mem(1'b0, 32'h0);
        #1;
        check("t5_refill_rd", bus.rd_o, 32'h55AA55AA);
`ifdef CACHE_STATS_EN
        check("t5_hit_count", hit_count, 32'd3);
        check("t5_miss_count", miss_count, 32'd4);
`endif

        // 6: asynchronous reset in the middle of a read miss
        next_cycle();
        access(1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
        #1;
        check("t6_detect_stall", 32'(bus.stall_o), 32'd1);
        next_cycle(); #1;
        check("t6_req_before_rst", 32'(bus.mem_req_o), 32'd1);
        #2;
        rst_i = 1'b1;
        #1;
        check("t6_rst_req", 32'(bus.mem_req_o), 32'd0);
        check("t6_rst_stall", 32'(bus.stall_o), 32'd0);
`ifdef CACHE_STATS_EN
        check("t6_rst_miss_count", miss_count, 32'd0);
`endif
        next_cycle();
        rst_i = 1'b0;
        access(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        mem(1'b1, 32'h77777777);
        #1;
        check("t6_late_ack_req", 32'(bus.mem_req_o), 32'd0);
        check("t6_late_ack_stall", 32'(bus.stall_o), 32'd0);
        next_cycle();
        mem(1'b0, 32'h0);
        access(1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
        #1;
        check("t6_after_rst_stall", 32'(bus.stall_o), 32'd1);
        check("t6_after_rst_rd", bus.rd_o, 32'd0);
        next_cycle(); #1;
        check("t6_after_rst_req", 32'(bus.mem_req_o), 32'd1);
        check("t6_after_rst_addr", bus.mem_addr_o, 32'h100);
        mem(1'b1, 32'h13579BDF);
        next_cycle();
        mem(1'b0, 32'h0);
        #1;
        check("t6_refill_rd", bus.rd_o, 32'h13579BDF);
        access(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
